// File: rtl/lsu_store_queue_pkg.sv
// Payload types shared by the LSU store request queue, its interface and its bench.
package lsu_store_queue_pkg;

    localparam int unsigned VLEN          = 64;
    localparam int unsigned XLEN          = 64;
    localparam int unsigned BE_W          = XLEN / 8;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [3:0] {
        OP_SB       = 4'd0,
        OP_SH       = 4'd1,
        OP_SW       = 4'd2,
        OP_SD       = 4'd3,
        OP_AMO_LR   = 4'd4,
        OP_AMO_SC   = 4'd5,
        OP_AMO_SWAP = 4'd6,
        OP_AMO_ADD  = 4'd7,
        OP_AMO_AND  = 4'd8,
        OP_AMO_OR   = 4'd9,
        OP_AMO_XOR  = 4'd10,
        OP_AMO_MAX  = 4'd11,
        OP_AMO_MIN  = 4'd12
    } fu_op_e;

    typedef struct packed {
        logic [VLEN-1:0]          vaddr;
        logic [XLEN-1:0]          data;
        logic [BE_W-1:0]          be;
        fu_op_e                   operation;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } lsu_ctrl_t;

endpackage

// File: rtl/lsu_store_queue_if.sv
// Handshake bundle between issue, the store request queue and store_unit.
interface lsu_store_queue_if;
    import lsu_store_queue_pkg::*;

    logic      valid_i;
    lsu_ctrl_t lsu_ctrl_i;
    logic      ready_o;
    logic      valid_o;
    lsu_ctrl_t lsu_ctrl_o;
    logic      pop_i;

    modport master (
        output valid_i, lsu_ctrl_i, pop_i,
        input  ready_o, valid_o, lsu_ctrl_o
    );

    modport slave (
        input  valid_i, lsu_ctrl_i, pop_i,
        output ready_o, valid_o, lsu_ctrl_o
    );

endinterface

// File: rtl/lsu_store_queue.sv
// FIFO of store/AMO requests feeding store_unit; head is held until popped.
// Optional zero-latency bypass of an empty queue: define LSU_STORE_QUEUE_BYPASS_EN.
module lsu_store_queue
    import lsu_store_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    lsu_store_queue_if.slave   sq,
    output logic [CNT_W-1:0]   count_o,
    output logic               empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    lsu_ctrl_t        mem_q [DEPTH];
    lsu_ctrl_t        mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty_c;
    logic full_c;
    logic push_c;
    logic pop_c;
    logic write_c;
    logic retire_c;

    // Status and head presentation; ready depends on registered fill level only.
    always_comb begin
        empty_c       = (count_q == '0);
        full_c        = (count_q == CNT_W'(DEPTH));
        sq.ready_o    = ~full_c;
        count_o       = count_q;
        empty_o       = empty_c;
`ifdef LSU_STORE_QUEUE_BYPASS_EN
        sq.valid_o    = ~empty_c | (sq.valid_i & ~flush_i);
        sq.lsu_ctrl_o = empty_c ? sq.lsu_ctrl_i : mem_q[rd_ptr_q];
`else
        sq.valid_o    = ~empty_c;
        sq.lsu_ctrl_o = mem_q[rd_ptr_q];
`endif
    end

    // Accepted transfers; a bypassed request consumed in the same cycle never touches storage.
    always_comb begin
        push_c   = sq.valid_i & ~full_c & ~flush_i;
        pop_c    = sq.pop_i & sq.valid_o & ~flush_i;
        retire_c = pop_c & ~empty_c;
`ifdef LSU_STORE_QUEUE_BYPASS_EN
        write_c  = push_c & ~(pop_c & empty_c);
`else
        write_c  = push_c;
`endif
    end

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (write_c) begin
                mem_d[wr_ptr_q] = sq.lsu_ctrl_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (retire_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({write_c, retire_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; only the pointers define what is live.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CNT_W'(DEPTH));

    // store_unit re-reads the head during its wait states, so it must not move until popped.
    a_head_hold : assert property (@(posedge clk_i) disable iff (rst_i)
        (sq.valid_o && !sq.pop_i && !flush_i) |=> (sq.valid_o && $stable(sq.lsu_ctrl_o)));

endmodule

// File: tb/tb_lsu_store_queue.sv
// Bench for lsu_store_queue: DEPTH=2 vector table plus a queue scoreboard on DEPTH=2 and DEPTH=4.
module tb_lsu_store_queue;
    import lsu_store_queue_pkg::*;

`ifdef LSU_STORE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic       p;
        logic       f;
        logic [2:0] id;
        logic       e_ready;
        logic       e_valid;
        logic [1:0] e_count;
        logic [2:0] e_id;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       flush2;
    logic       flush4;
    logic [1:0] count2;
    logic [2:0] count4;
    logic       empty2;
    logic       empty4;

    int checks = 0;
    int errors = 0;

    lsu_ctrl_t sb2[$];
    lsu_ctrl_t sb4[$];
    vec_t      tbl[$];

    lsu_store_queue_if if2 ();
    lsu_store_queue_if if4 ();

    lsu_store_queue #(.DEPTH(2)) dut2 (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush2),
        .sq      (if2),
        .count_o (count2),
        .empty_o (empty2)
    );

    lsu_store_queue #(.DEPTH(4)) dut4 (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush4),
        .sq      (if4),
        .count_o (count4),
        .empty_o (empty4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic lsu_ctrl_t mk(input logic [2:0] id);
        lsu_ctrl_t r;
        r.vaddr     = {$urandom(), $urandom()};
        r.data      = {$urandom(), $urandom()};
        r.be        = 8'($urandom());
        r.operation = id[0] ? OP_AMO_ADD : OP_SD;
        r.trans_id  = id;
        return r;
    endfunction

    function automatic vec_t vec(input logic v, p, f, input logic [2:0] id,
                                 input logic er, ev, input logic [1:0] ec, input logic [2:0] eid);
        vec_t r;
        r.v = v; r.p = p; r.f = f; r.id = id;
        r.e_ready = er; r.e_valid = ev; r.e_count = ec; r.e_id = eid;
        return r;
    endfunction

    // Reference queue: compares one cycle of DUT outputs, then applies that cycle's transfer.
    task automatic mon(input string tag, input int depth, input logic valid_i, pop_i, flush,
                       input logic ready_o, valid_o, input lsu_ctrl_t in, out,
                       input int unsigned count, input logic empty,
                       input lsu_ctrl_t q_in[$], output lsu_ctrl_t q_out[$]);
        lsu_ctrl_t q[$];
        lsu_ctrl_t head;
        int  size;
        logic ev, push, pop;
        q    = q_in;
        size = q.size();
        ev   = (size != 0) || (BYP && valid_i && !flush);
        chk({tag, " ready"}, 256'(ready_o), 256'(size < depth));
        chk({tag, " valid"}, 256'(valid_o), 256'(ev));
        chk({tag, " count"}, 256'(count), 256'(size));
        chk({tag, " empty"}, 256'(empty), 256'(size == 0));
        if (ev) begin
            head = (size != 0) ? q[0] : in;
            chk({tag, " head"}, 256'(out), 256'(head));
        end
        pop  = pop_i && ev && !flush;
        push = valid_i && (size < depth) && !flush;
        if (flush) begin
            q.delete();
        end else if (!(push && pop && size == 0)) begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(in);
        end
        q_out = q;
    endtask

    always @(negedge clk) begin
        #2;
        if (rst) begin
            sb2.delete();
            sb4.delete();
        end else begin
            mon("d2", 2, if2.valid_i, if2.pop_i, flush2, if2.ready_o, if2.valid_o,
                if2.lsu_ctrl_i, if2.lsu_ctrl_o, 32'(count2), empty2, sb2, sb2);
            mon("d4", 4, if4.valid_i, if4.pop_i, flush4, if4.ready_o, if4.valid_o,
                if4.lsu_ctrl_i, if4.lsu_ctrl_o, 32'(count4), empty4, sb4, sb4);
        end
    end

    task automatic drive2(input logic v, p, f, input logic [2:0] id);
        @(negedge clk);
        if2.valid_i    = v;
        if2.pop_i      = p;
        flush2         = f;
        if2.lsu_ctrl_i = mk(id);
        #1;
    endtask

    task automatic drive4(input logic v, p, f, input logic [2:0] id);
        @(negedge clk);
        if4.valid_i    = v;
        if4.pop_i      = p;
        flush4         = f;
        if4.lsu_ctrl_i = mk(id);
        #1;
    endtask

    initial begin
        int   sent;
        logic ev;
        logic [2:0] eid;

        rst            = 1'b1;
        flush2         = 1'b0;
        flush4         = 1'b0;
        if2.valid_i    = 1'b0;
        if2.pop_i      = 1'b0;
        if2.lsu_ctrl_i = '0;
        if4.valid_i    = 1'b0;
        if4.pop_i      = 1'b0;
        if4.lsu_ctrl_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        //            v  p  f  id  rdy val cnt hid
        tbl.push_back(vec(0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(vec(1, 0, 0, 3, 1, 0, 0, 0));
        tbl.push_back(vec(1, 0, 0, 4, 1, 1, 1, 3));
        tbl.push_back(vec(0, 0, 0, 0, 0, 1, 2, 3));
        tbl.push_back(vec(0, 1, 0, 0, 0, 1, 2, 3));
        tbl.push_back(vec(0, 1, 0, 0, 1, 1, 1, 4));
        tbl.push_back(vec(0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(vec(1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(vec(1, 0, 0, 2, 1, 1, 1, 1));
        tbl.push_back(vec(1, 1, 0, 6, 0, 1, 2, 1));
        tbl.push_back(vec(0, 0, 0, 0, 1, 1, 1, 2));
        tbl.push_back(vec(1, 1, 0, 5, 1, 1, 1, 2));
        tbl.push_back(vec(0, 0, 0, 0, 1, 1, 1, 5));
        tbl.push_back(vec(0, 0, 0, 0, 1, 1, 1, 5));
        tbl.push_back(vec(0, 0, 0, 0, 1, 1, 1, 5));
        tbl.push_back(vec(0, 0, 0, 0, 1, 1, 1, 5));
        tbl.push_back(vec(1, 0, 0, 0, 1, 1, 1, 5));
        tbl.push_back(vec(1, 0, 1, 7, 0, 1, 2, 5));
        tbl.push_back(vec(0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(vec(1, 0, 0, 4, 1, 0, 0, 0));
        tbl.push_back(vec(1, 0, 1, 6, 1, 1, 1, 4));
        tbl.push_back(vec(0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(vec(0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(vec(0, 0, 0, 0, 1, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive2(tbl[i].v, tbl[i].p, tbl[i].f, tbl[i].id);
            ev  = tbl[i].e_valid;
            eid = tbl[i].e_id;
            if (BYP && tbl[i].e_count == 2'd0 && tbl[i].v && !tbl[i].f) begin
                ev  = 1'b1;
                eid = tbl[i].id;
            end
            chk($sformatf("row%0d ready", i), 256'(if2.ready_o), 256'(tbl[i].e_ready));
            chk($sformatf("row%0d valid", i), 256'(if2.valid_o), 256'(ev));
            chk($sformatf("row%0d count", i), 256'(count2), 256'(tbl[i].e_count));
            chk($sformatf("row%0d empty", i), 256'(empty2), 256'(tbl[i].e_count == 2'd0));
            if (ev) chk($sformatf("row%0d head id", i), 256'(if2.lsu_ctrl_o.trans_id), 256'(eid));
        end

        // Empty queue, request 7 arrives together with pop_i.
        drive2(1, 1, 0, 7);
`ifdef LSU_STORE_QUEUE_BYPASS_EN
        chk("bypass valid", 256'(if2.valid_o), 256'(1'b1));
        chk("bypass id", 256'(if2.lsu_ctrl_o.trans_id), 256'(3'd7));
        drive2(0, 0, 0, 0);
        chk("bypass count", 256'(count2), 256'(2'd0));
        chk("bypass after valid", 256'(if2.valid_o), 256'(1'b0));
`else
        chk("latency valid", 256'(if2.valid_o), 256'(1'b0));
        drive2(0, 0, 0, 0);
        chk("latency valid next", 256'(if2.valid_o), 256'(1'b1));
        chk("latency id next", 256'(if2.lsu_ctrl_o.trans_id), 256'(3'd7));
        chk("latency count next", 256'(count2), 256'(2'd1));
`endif
        drive2(0, 1, 0, 0);
        drive2(0, 0, 0, 0);
        chk("t5 drained", 256'(count2), 256'(2'd0));

        // DEPTH=4: six requests under random pops wrap both pointers.
        sent = 0;
        for (int c = 0; c < 60 && sent < 6; c++) begin
            drive4(1, 1'($urandom_range(0, 1)), 0, 3'(sent));
            if (sb4.size() < 4) sent++;
        end
        chk("t6 push budget", 256'(sent), 256'(6));
        drive4(1, 0, 0, 6);
        drive4(0, 0, 0, 0);
        chk("t6 nonempty before reset", 256'(empty4), 256'(1'b0));
        @(negedge clk);
        rst         = 1'b1;
        if4.valid_i = 1'b0;
        if4.pop_i   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6 rst count", 256'(count4), 256'(3'd0));
        chk("t6 rst valid", 256'(if4.valid_o), 256'(1'b0));
        chk("t6 rst empty", 256'(empty4), 256'(1'b1));
        chk("t6 rst ready", 256'(if4.ready_o), 256'(1'b1));

        repeat (3) @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
